// File: rtl/vga_pkg.sv
// Shared defaults, write-entry type and grant encoding for the VGA
// frame-buffer arbiter.
package vga_pkg;

  localparam int VGA_ADDR_WIDTH = 15;
  localparam int VGA_DATA_WIDTH = 8;

  typedef struct packed {
    logic [VGA_ADDR_WIDTH-1:0] addr;
    logic [VGA_DATA_WIDTH-1:0] data;
  } vga_wr_t;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_READ  = 2'd1,
    GNT_WRITE = 2'd2
  } vga_gnt_e;

  // Display reads always win; buffered writes only fill otherwise idle slots.
  function automatic vga_gnt_e gnt_select(input logic req, input logic buf_empty);
    if (req) begin
      return GNT_READ;
    end else if (!buf_empty) begin
      return GNT_WRITE;
    end
    return GNT_IDLE;
  endfunction

endpackage

// File: rtl/vga_wr_fifo.sv
// Synchronous write buffer. Pointers carry one extra wrap bit so that
// full and empty are distinguished without an occupancy counter.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(vga_wr_t)
) (
  input  logic             CLK,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_fbuf_arbiter.sv
// Single-port frame-buffer arbiter: display reads with fixed priority and a
// three-cycle return path; AHB pixel writes buffered and drained into idle slots.
module vga_fbuf_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = VGA_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VGA_DATA_WIDTH,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                  CLK,
  input  logic                  resetn,
  input  logic                  disp_req,
  input  logic [ADDR_WIDTH-1:0] disp_addr,
  output logic [DATA_WIDTH-1:0] disp_data,
  output logic                  disp_rvalid,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fifo_empty,
  output logic                  err_starve,
  input  logic                  err_clr
);

  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W   = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_entry_t;

  vga_gnt_e         gnt;
  wr_entry_t        push_entry;
  wr_entry_t        head_entry;
  logic             fifo_full;
  logic             fifo_push;
  logic             fifo_pop;
  logic             rd_issued;
  logic             rd_returning;
  logic [CNT_W-1:0] starve_cnt;
  logic             starve_hit;

  // Handshake: a pixel transfers on a rising CLK edge where wr_valid && wr_ready;
  // wr_ready depends only on buffer fullness, never on wr_valid or on a same-cycle pop.
  assign wr_ready   = !fifo_full;
  assign fifo_push  = wr_valid && !fifo_full;
  assign push_entry = {wr_addr, wr_data};

  always_comb begin
    gnt = gnt_select(disp_req, fifo_empty);
  end

  assign fifo_pop = (gnt == GNT_WRITE);

  vga_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wr_fifo (
    .CLK       (CLK),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // RAM strobe register; address and write data hold when the slot is idle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_cs <= (gnt != GNT_IDLE);
      mem_we <= (gnt == GNT_WRITE);
      case (gnt)
        GNT_READ: begin
          mem_addr <= disp_addr;
        end
        GNT_WRITE: begin
          mem_addr  <= head_entry.addr;
          mem_wdata <= head_entry.data;
        end
        default: begin
        end
      endcase
    end
  end

  // Read return: strobe cycle -> RAM data cycle -> registered to the display.
  assign rd_issued = mem_cs && !mem_we;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      rd_returning <= 1'b0;
      disp_rvalid  <= 1'b0;
      disp_data    <= '0;
    end else begin
      rd_returning <= rd_issued;
      disp_rvalid  <= rd_returning;
      if (rd_returning) begin
        disp_data <= mem_rdata;
      end
    end
  end

  // A non-empty buffer that is not popping is necessarily blocked by a read.
  assign starve_hit = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (fifo_pop || fifo_empty) begin
      starve_cnt <= '0;
    end else if (disp_req && !starve_hit) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      err_starve <= 1'b0;
    end else if (starve_hit) begin
      err_starve <= 1'b1;
    end else if (err_clr) begin
      err_starve <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_fbuf_arbiter.sv
// Directed bench for vga_fbuf_arbiter with a synchronous RAM model, a write
// scoreboard and a read-latency monitor.
module tb_vga_fbuf_arbiter;

  localparam int AW = 15;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          resetn;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_rvalid;
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          mem_cs;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          fifo_empty;
  logic          err_starve;
  logic          err_clr;

  vga_fbuf_arbiter dut (
    .CLK         (CLK),
    .resetn      (resetn),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_rvalid (disp_rvalid),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .mem_cs      (mem_cs),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .fifo_empty  (fifo_empty),
    .err_starve  (err_starve),
    .err_clr     (err_clr)
  );

  // Clock and RAM model
  always #5 CLK = ~CLK;

  logic [DW-1:0] ram [1 << AW];

  always @(posedge CLK) begin
    if (mem_cs) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Scoreboard: accepted writes must reach the RAM in order; every read
  // request must return exactly three cycles later with the RAM contents.
  logic [AW+DW-1:0] exp_q[$];
  logic [2:0]       req_hist = '0;
  logic [DW-1:0]    data_hist [3];
  int               n_we = 0;

  always @(negedge CLK) begin
    if (!resetn) begin
      check("rvalid_in_reset", disp_rvalid, 0);
      check("mem_cs_in_reset", mem_cs, 0);
      exp_q.delete();
      req_hist = '0;
    end else begin
      check("rvalid_latency", disp_rvalid, req_hist[2]);
      if (req_hist[2] && disp_rvalid) check("rdata", disp_data, data_hist[2]);
      if (mem_cs && mem_we) begin
        n_we++;
        check("wr_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("wr_order", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      if (wr_valid && wr_ready) exp_q.push_back({wr_addr, wr_data});
      req_hist     = {req_hist[1:0], disp_req};
      data_hist[2] = data_hist[1];
      data_hist[1] = data_hist[0];
      data_hist[0] = ram[disp_addr];
    end
  end

  // Driver helpers
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    disp_req = 1'b0;
    wr_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  int we0;
  int wa;
  logic acc;

  initial begin
    for (int i = 0; i < (1 << AW); i++) ram[i] = 8'(i) ^ 8'h3C;
    ram[16] = 8'hA5;
    resetn    = 1'b0;
    disp_addr = '0;
    wr_addr   = '0;
    wr_data   = '0;
    idle();

    // Reset values
    repeat (3) nxt();
    check("rst_rvalid", disp_rvalid, 0);
    check("rst_data",   disp_data, 0);
    check("rst_ready",  wr_ready, 1);
    check("rst_cs",     mem_cs, 0);
    check("rst_we",     mem_we, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_wdata",  mem_wdata, 0);
    check("rst_empty",  fifo_empty, 1);
    check("rst_err",    err_starve, 0);
    resetn = 1'b1;
    nxt();

    // 1: single read of 0x0010 returns 0xA5 three cycles later
    disp_req  = 1'b1;
    disp_addr = 15'h0010;
    nxt();
    disp_req = 1'b0;
    check("t1_cs",     mem_cs, 1);
    check("t1_we",     mem_we, 0);
    check("t1_addr",   mem_addr, 15'h0010);
    check("t1_rv_c1",  disp_rvalid, 0);
    nxt();
    check("t1_rv_c2",  disp_rvalid, 0);
    nxt();
    check("t1_rv_c3",  disp_rvalid, 1);
    check("t1_data",   disp_data, 8'hA5);
    nxt();
    check("t1_rv_c4",  disp_rvalid, 0);

    // 2: four writes with no display traffic
    we0 = n_we;
    for (int c = 0; c < 6; c++) begin
      wr_valid = (c < 4);
      wr_addr  = 15'h100 + 15'(c);
      wr_data  = 8'h10 + 8'(c);
      if (c < 4) check("t2_ready", wr_ready, 1);
      nxt();
      check("t2_we", mem_we, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check("t2_addr", mem_addr, 15'h100 + 15'(c - 1));
    end
    check("t2_empty",  fifo_empty, 1);
    check("t2_nwe",    n_we - we0, 4);

    // 3: reads block the buffer until it fills, then it drains in four cycles
    we0       = n_we;
    disp_req  = 1'b1;
    disp_addr = 15'h0020;
    for (int c = 0; c < 5; c++) begin
      wr_valid = 1'b1;
      wr_addr  = 15'h300 + 15'(c);
      wr_data  = 8'h60 + 8'(c);
      check("t3_ready", wr_ready, (c < 4));
      nxt();
      disp_addr = disp_addr + 15'd1;
    end
    for (int c = 0; c < 3; c++) begin
      check("t3_full_ready", wr_ready, 0);
      check("t3_full_we",    mem_we, 0);
      nxt();
      disp_addr = disp_addr + 15'd1;
    end
    idle();
    check("t3_ready_pre", wr_ready, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      if (k == 0) check("t3_ready_post", wr_ready, 1);
      check("t3_drain_we",   mem_we, 1);
      check("t3_drain_addr", mem_addr, 15'h300 + 15'(k));
    end
    check("t3_empty", fifo_empty, 1);
    nxt();
    check("t3_we_done", mem_we, 0);
    check("t3_nwe",     n_we - we0, 4);

    // 4: alternating reads with continuous writes interleave 1:1
    wa = 0;
    for (int k = 0; k < 16; k++) begin
      disp_req  = (k % 2 == 0);
      disp_addr = 15'h0040 + 15'(k);
      wr_valid  = 1'b1;
      wr_addr   = 15'h400 + 15'(wa);
      wr_data   = 8'hC0 + 8'(wa);
      acc       = wr_ready;
      nxt();
      if (acc) wa++;
      check("t4_cs", mem_cs, 1);
      check("t4_we", mem_we, (k % 2 == 1));
    end
    idle();
    repeat (8) nxt();
    check("t4_empty",    fifo_empty, 1);
    check("t4_sb_empty", exp_q.size(), 0);
    check("t4_err",      err_starve, 0);

    // 5: sustained reads over a pending write raise err_starve
    disp_req  = 1'b1;
    disp_addr = 15'h0060;
    wr_valid  = 1'b1;
    wr_addr   = 15'h500;
    wr_data   = 8'hEE;
    check("t5_ready", wr_ready, 1);
    nxt();
    wr_valid = 1'b0;
    repeat (64) nxt();
    check("t5_err_pre",    err_starve, 0);
    nxt();
    check("t5_err_set",    err_starve, 1);
    err_clr = 1'b1;
    nxt();
    check("t5_err_setwin", err_starve, 1);
    err_clr  = 1'b0;
    disp_req = 1'b0;
    nxt();
    check("t5_err_sticky", err_starve, 1);
    check("t5_drain_we",   mem_we, 1);
    err_clr = 1'b1;
    nxt();
    check("t5_err_clr",    err_starve, 0);
    check("t5_empty",      fifo_empty, 1);
    err_clr = 1'b0;
    repeat (3) nxt();

    // 6: reset mid-drain with three buffered writes and reads in flight
    disp_req  = 1'b1;
    disp_addr = 15'h0070;
    for (int c = 0; c < 4; c++) begin
      wr_valid = 1'b1;
      wr_addr  = 15'h600 + 15'(c);
      wr_data  = 8'h80 + 8'(c);
      nxt();
    end
    idle();
    nxt();
    check("t6_first_pop", mem_we, 1);
    check("t6_not_empty", fifo_empty, 0);
    resetn = 1'b0;
    #1;
    check("t6_rst_cs",    mem_cs, 0);
    check("t6_rst_rv",    disp_rvalid, 0);
    check("t6_rst_empty", fifo_empty, 1);
    check("t6_rst_ready", wr_ready, 1);
    repeat (2) nxt();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      nxt();
      check("t6_post_cs",    mem_cs, 0);
      check("t6_post_rv",    disp_rvalid, 0);
      check("t6_post_empty", fifo_empty, 1);
      check("t6_post_ready", wr_ready, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
